// File: rtl/fifo_merge_pkg.sv
// Shared state encoding, default sizes and width helper for the FIFO merge arbiter.
package fifo_merge_pkg;

    typedef enum logic [0:0] {
        StIdle    = 1'b0,
        StGranted = 1'b1
    } merge_state_e;

    localparam int unsigned DefChannels  = 2;
    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefMaxBurst  = 1;

    // Bits needed to encode values 0..value-1; never below 1 so ports stay legal.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Rotating-priority picker: returns the first set request at or after start_i,
// or the lowest set request when FIXED_PRIORITY is non-zero.
module rr_priority_select
    import fifo_merge_pkg::*;
#(
    parameter int unsigned CHANNELS       = DefChannels,
    parameter int unsigned FIXED_PRIORITY = 0,
    localparam int unsigned IdW           = clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [IdW-1:0]      start_i,
    output logic                found_o,
    output logic [IdW-1:0]      sel_o
);

    logic [IdW-1:0] base;
    logic [IdW-1:0] idx;

    assign base = (FIXED_PRIORITY != 0) ? '0 : start_i;

    always_comb begin
        found_o = 1'b0;
        sel_o   = '0;
        idx     = base;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (!found_o && req_i[idx]) begin
                found_o = 1'b1;
                sel_o   = idx;
            end
            idx = (idx == IdW'(CHANNELS - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_merge_arbiter.sv
// Merges several source FIFOs onto one read-side interface with round-robin or
// fixed-priority arbitration, bounded bursts per grant and per-channel enables.
module fifo_merge_arbiter
    import fifo_merge_pkg::*;
#(
    parameter int unsigned CHANNELS       = DefChannels,
    parameter int unsigned DATA_WIDTH     = DefDataWidth,
    parameter int unsigned MAX_BURST      = DefMaxBurst,
    parameter int unsigned FIXED_PRIORITY = 0,
    localparam int unsigned IdW           = clog2(CHANNELS),
    localparam int unsigned CntW          = clog2(MAX_BURST + 1)
) (
    input  logic                           BUS_CLK,
    input  logic                           BUS_RST,
    input  logic [CHANNELS-1:0]            CH_ENABLE,
    input  logic [CHANNELS-1:0]            CH_FIFO_EMPTY,
    input  logic [CHANNELS*DATA_WIDTH-1:0] CH_FIFO_DATA,
    output logic [CHANNELS-1:0]            CH_FIFO_READ,
    input  logic                           FIFO_READ,
    output logic                           FIFO_EMPTY,
    output logic [DATA_WIDTH-1:0]          FIFO_DATA,
    output logic                           GRANT_VALID,
    output logic [IdW-1:0]                 GRANT_ID
);

    localparam logic [CntW-1:0] BurstLast = CntW'(MAX_BURST - 1);
    localparam logic [CntW-1:0] BurstMax  = CntW'(MAX_BURST);

    merge_state_e    state_q, state_d;
    logic [IdW-1:0]  grant_q, grant_d;
    logic [IdW-1:0]  ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [CHANNELS-1:0] req;
    logic [CHANNELS-1:0] grant_oh;
    logic [CHANNELS-1:0] search_req;
    logic                found;
    logic [IdW-1:0]      sel;
    logic                granted;
    logic                g_empty;
    logic                g_enable;
    logic                fwd_read;
    logic                release_grant;

    function automatic logic [IdW-1:0] next_index(input logic [IdW-1:0] idx);
        return (idx == IdW'(CHANNELS - 1)) ? '0 : idx + 1'b1;
    endfunction

    assign req      = CH_ENABLE & ~CH_FIFO_EMPTY;
    assign granted  = (state_q == StGranted);
    assign g_empty  = CH_FIFO_EMPTY[grant_q];
    assign g_enable = CH_ENABLE[grant_q];
    // Reads are never forwarded while reset is held, even before the grant drops.
    assign fwd_read = granted & FIFO_READ & ~g_empty & ~BUS_RST;

    assign release_grant = (fwd_read && cnt_q == BurstLast) || (!fwd_read && g_empty) ||
                           !g_enable;

    always_comb begin
        grant_oh          = '0;
        grant_oh[grant_q] = 1'b1;
    end

    // While granted, the holder is excluded so a release hands over to anyone else first.
    assign search_req = granted ? (req & ~grant_oh) : req;

    rr_priority_select #(
        .CHANNELS       (CHANNELS),
        .FIXED_PRIORITY (FIXED_PRIORITY)
    ) u_select (
        .req_i   (search_req),
        .start_i (ptr_q),
        .found_o (found),
        .sel_o   (sel)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StGranted;
                    grant_d = sel;
                    ptr_d   = next_index(sel);
                    cnt_d   = '0;
                end
            end
            StGranted: begin
                if (fwd_read && cnt_q != BurstMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (release_grant) begin
                    cnt_d = '0;
                    if (found) begin
                        grant_d = sel;
                        ptr_d   = next_index(sel);
                    end else if (!req[grant_q]) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        FIFO_EMPTY   = 1'b1;
        FIFO_DATA    = '0;
        CH_FIFO_READ = '0;
        if (granted) begin
            FIFO_EMPTY            = g_empty;
            FIFO_DATA             = CH_FIFO_DATA[grant_q*DATA_WIDTH +: DATA_WIDTH];
            CH_FIFO_READ[grant_q] = fwd_read;
        end
    end

    assign GRANT_VALID = granted;
    assign GRANT_ID    = grant_q;

endmodule

// File: tb/tb_fifo_merge_arbiter.sv
// Directed bench for fifo_merge_arbiter: three configurations share one modelled set of
// four source FIFOs; dut_sel picks which instance's read strobes drain the sources.
module tb_fifo_merge_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         fifo_read;
    logic [3:0]   ch_en;
    logic [3:0]   ch_empty;
    logic [127:0] ch_data;

    logic [1:0]  rd_a;
    logic        empty_a, valid_a;
    logic [31:0] data_a;
    logic        gid_a;
    logic [3:0]  rd_b;
    logic        empty_b, valid_b;
    logic [31:0] data_b;
    logic [1:0]  gid_b;
    logic [3:0]  rd_c;
    logic        empty_c, valid_c;
    logic [31:0] data_c;
    logic [1:0]  gid_c;

    fifo_merge_arbiter #(.CHANNELS(2), .DATA_WIDTH(32), .MAX_BURST(1), .FIXED_PRIORITY(0)) dut_a (
        .BUS_CLK(clk), .BUS_RST(rst), .CH_ENABLE(ch_en[1:0]), .CH_FIFO_EMPTY(ch_empty[1:0]),
        .CH_FIFO_DATA(ch_data[63:0]), .CH_FIFO_READ(rd_a), .FIFO_READ(fifo_read),
        .FIFO_EMPTY(empty_a), .FIFO_DATA(data_a), .GRANT_VALID(valid_a), .GRANT_ID(gid_a)
    );
    fifo_merge_arbiter #(.CHANNELS(4), .DATA_WIDTH(32), .MAX_BURST(4), .FIXED_PRIORITY(0)) dut_b (
        .BUS_CLK(clk), .BUS_RST(rst), .CH_ENABLE(ch_en), .CH_FIFO_EMPTY(ch_empty),
        .CH_FIFO_DATA(ch_data), .CH_FIFO_READ(rd_b), .FIFO_READ(fifo_read),
        .FIFO_EMPTY(empty_b), .FIFO_DATA(data_b), .GRANT_VALID(valid_b), .GRANT_ID(gid_b)
    );
    fifo_merge_arbiter #(.CHANNELS(4), .DATA_WIDTH(32), .MAX_BURST(8), .FIXED_PRIORITY(1)) dut_c (
        .BUS_CLK(clk), .BUS_RST(rst), .CH_ENABLE(ch_en), .CH_FIFO_EMPTY(ch_empty),
        .CH_FIFO_DATA(ch_data), .CH_FIFO_READ(rd_c), .FIFO_READ(fifo_read),
        .FIFO_EMPTY(empty_c), .FIFO_DATA(data_c), .GRANT_VALID(valid_c), .GRANT_ID(gid_c)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int dut_sel = 0;
    int src_cnt[4];
    int src_idx[4];

    logic [3:0]  obs_read;
    logic        obs_empty, obs_valid;
    logic [31:0] obs_data;
    int          obs_gid;

    int          log_ch[$];
    logic [31:0] log_data[$];
    int          log_cyc[$];

    function automatic logic [31:0] word_of(input int ch, input int idx);
        return 32'hA000_0000 | (32'(ch) << 16) | 32'(idx);
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            ch_empty[i]        = (src_cnt[i] == 0);
            ch_data[i*32 +: 32] = word_of(i, src_idx[i]);
        end
    endtask

    task automatic load(input int ch, input int n);
        src_cnt[ch] = n;
        drive_inputs();
    endtask

    // Sample the selected DUT mid-cycle, then pop the modelled sources after the edge.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        case (dut_sel)
            0: begin
                obs_read = {2'b00, rd_a}; obs_empty = empty_a; obs_data = data_a;
                obs_valid = valid_a; obs_gid = int'(gid_a);
            end
            1: begin
                obs_read = rd_b; obs_empty = empty_b; obs_data = data_b;
                obs_valid = valid_b; obs_gid = int'(gid_b);
            end
            default: begin
                obs_read = rd_c; obs_empty = empty_c; obs_data = data_c;
                obs_valid = valid_c; obs_gid = int'(gid_c);
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            if (obs_read[i]) begin
                checks++;
                if (src_cnt[i] == 0) $display("FAIL read_of_empty ch%0d: got count 0 want >0", i);
                else passed++;
                log_ch.push_back(i);
                log_data.push_back(obs_data);
                log_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (obs_read[i] && src_cnt[i] > 0) begin
                src_cnt[i]--;
                src_idx[i]++;
            end
        end
        drive_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fifo_read = 1'b0;
        ch_en = 4'hF;
        for (int i = 0; i < 4; i++) begin
            src_cnt[i] = 0;
            src_idx[i] = 0;
        end
        drive_inputs();
        cycle();
        cycle();
        rst = 1'b0;
        log_ch.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic run_reads(input int n, input int budget, input string name);
        int k = 0;
        while (log_ch.size() < n && k < budget) begin
            cycle();
            k++;
        end
        checks++;
        if (log_ch.size() < n) $display("FAIL %s_timeout: got %0d reads want %0d", name,
                                        log_ch.size(), n);
        else passed++;
    endtask

    task automatic check_log(input int k, input int ch, input int idx, input string name);
        checks++;
        if (log_ch[k] !== ch) $display("FAIL %s_ch[%0d]: got %0d want %0d", name, k, log_ch[k], ch);
        else passed++;
        checks++;
        if (log_data[k] !== word_of(ch, idx))
            $display("FAIL %s_data[%0d]: got %h want %h", name, k, log_data[k], word_of(ch, idx));
        else passed++;
    endtask

    task automatic test_reset();
        do_reset();
        fifo_read = 1'b1;
        for (int s = 0; s < 3; s++) begin
            dut_sel = s;
            cycle();
            checks++;
            if (obs_empty !== 1'b1) $display("FAIL reset_empty dut%0d: got %b want 1", s, obs_empty);
            else passed++;
            checks++;
            if (obs_valid !== 1'b0) $display("FAIL reset_valid dut%0d: got %b want 0", s, obs_valid);
            else passed++;
            checks++;
            if (obs_read !== 4'b0) $display("FAIL reset_read dut%0d: got %b want 0000", s, obs_read);
            else passed++;
            checks++;
            if (obs_data !== 32'h0) $display("FAIL reset_data dut%0d: got %h want 0", s, obs_data);
            else passed++;
            checks++;
            if (obs_gid !== 0) $display("FAIL reset_gid dut%0d: got %0d want 0", s, obs_gid);
            else passed++;
        end
    endtask

    task automatic test_rr_burst1();
        dut_sel = 0;
        do_reset();
        load(0, 3);
        load(1, 3);
        fifo_read = 1'b1;
        cycle();
        checks++;
        if (obs_empty !== 1'b1) $display("FAIL rr1_idle_empty: got %b want 1", obs_empty);
        else passed++;
        cycle();
        checks++;
        if (obs_empty !== 1'b0) $display("FAIL rr1_latency_empty: got %b want 0", obs_empty);
        else passed++;
        run_reads(6, 20, "rr1");
        for (int k = 0; k < 6; k++) begin
            check_log(k, k % 2, k / 2, "rr1");
            checks++;
            if (log_cyc[k] !== log_cyc[0] + k)
                $display("FAIL rr1_gap[%0d]: got cycle %0d want %0d", k, log_cyc[k], log_cyc[0] + k);
            else passed++;
        end
        cycle();
        cycle();
        checks++;
        if (obs_valid !== 1'b0) $display("FAIL rr1_drain_idle: got %b want 0", obs_valid);
        else passed++;
    endtask

    task automatic test_burst_limit();
        int exp_ch[12] = '{0, 0, 0, 0, 3, 3, 3, 3, 0, 0, 3, 3};
        int exp_ix[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 4, 5};
        dut_sel = 1;
        do_reset();
        load(1, 2);
        load(2, 10);
        fifo_read = 1'b1;
        run_reads(12, 30, "burst");
        for (int k = 0; k < 12; k++) begin
            check_log(k, (k < 2) ? 1 : 2, (k < 2) ? k : k - 2, "burst");
        end
        checks++;
        if (log_cyc[2] !== log_cyc[1] + 2)
            $display("FAIL burst_empty_gap: got cycle %0d want %0d", log_cyc[2], log_cyc[1] + 2);
        else passed++;
        for (int k = 3; k < 12; k++) begin
            checks++;
            if (log_cyc[k] !== log_cyc[k-1] + 1)
                $display("FAIL burst_regrant_gap[%0d]: got cycle %0d want %0d", k, log_cyc[k],
                         log_cyc[k-1] + 1);
            else passed++;
        end
        do_reset();
        load(0, 6);
        load(3, 6);
        fifo_read = 1'b1;
        run_reads(12, 30, "groups");
        for (int k = 0; k < 12; k++) begin
            check_log(k, exp_ch[k], exp_ix[k], "groups");
        end
    endtask

    task automatic test_fixed_priority();
        dut_sel = 2;
        do_reset();
        load(3, 20);
        fifo_read = 1'b1;
        run_reads(3, 10, "fp_a");
        load(0, 2);
        run_reads(11, 30, "fp_a");
        for (int k = 0; k < 11; k++) begin
            if (k < 8) check_log(k, 3, k, "fp_a");
            else if (k < 10) check_log(k, 0, k - 8, "fp_a");
            else check_log(k, 3, 8, "fp_a");
        end
        do_reset();
        load(1, 8);
        load(2, 3);
        fifo_read = 1'b1;
        run_reads(2, 10, "fp_b");
        load(0, 2);
        run_reads(13, 40, "fp_b");
        for (int k = 0; k < 13; k++) begin
            if (k < 8) check_log(k, 1, k, "fp_b");
            else if (k < 10) check_log(k, 0, k - 8, "fp_b");
            else check_log(k, 2, k - 10, "fp_b");
        end
    endtask

    task automatic test_enable_drop();
        dut_sel = 1;
        do_reset();
        load(0, 5);
        load(1, 5);
        fifo_read = 1'b1;
        cycle();
        cycle();
        ch_en = 4'b1110;
        cycle();
        checks++;
        if (obs_read !== 4'b0001) $display("FAIL en_drop_read: got %b want 0001", obs_read);
        else passed++;
        checks++;
        if (obs_data !== word_of(0, 1))
            $display("FAIL en_drop_data: got %h want %h", obs_data, word_of(0, 1));
        else passed++;
        cycle();
        checks++;
        if (obs_gid !== 1 || obs_valid !== 1'b1)
            $display("FAIL en_switch_gid: got %0d/%b want 1/1", obs_gid, obs_valid);
        else passed++;
        checks++;
        if (obs_read !== 4'b0010) $display("FAIL en_switch_read: got %b want 0010", obs_read);
        else passed++;
        checks++;
        if (obs_data !== word_of(1, 0))
            $display("FAIL en_switch_data: got %h want %h", obs_data, word_of(1, 0));
        else passed++;
        ch_en = 4'b1100;
        fifo_read = 1'b0;
        cycle();
        checks++;
        if (obs_read !== 4'b0000) $display("FAIL en_noread: got %b want 0000", obs_read);
        else passed++;
        cycle();
        checks++;
        if (obs_valid !== 1'b0 || obs_empty !== 1'b1)
            $display("FAIL en_idle: got valid %b empty %b want 0 1", obs_valid, obs_empty);
        else passed++;
    endtask

    task automatic test_reset_mid_burst();
        dut_sel = 1;
        do_reset();
        load(2, 10);
        fifo_read = 1'b1;
        cycle();
        cycle();
        cycle();
        rst = 1'b1;
        load(0, 1);
        load(3, 1);
        cycle();
        checks++;
        if (obs_read !== 4'b0000) $display("FAIL rst_gate_read: got %b want 0000", obs_read);
        else passed++;
        rst = 1'b0;
        fifo_read = 1'b0;
        cycle();
        checks++;
        if (obs_valid !== 1'b0 || obs_empty !== 1'b1)
            $display("FAIL rst_drop: got valid %b empty %b want 0 1", obs_valid, obs_empty);
        else passed++;
        cycle();
        checks++;
        if (obs_valid !== 1'b1 || obs_gid !== 0)
            $display("FAIL rst_restart_gid: got %b/%0d want 1/0", obs_valid, obs_gid);
        else passed++;
        checks++;
        if (obs_data !== word_of(0, 0))
            $display("FAIL rst_restart_data: got %h want %h", obs_data, word_of(0, 0));
        else passed++;
    endtask

    initial begin
        rst = 1'b1;
        fifo_read = 1'b0;
        ch_en = 4'hF;
        ch_empty = 4'hF;
        ch_data = '0;
        test_reset();
        test_rr_burst1();
        test_burst_limit();
        test_fixed_priority();
        test_enable_drop();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fifo_merge_arbiter.md
# fifo_merge_arbiter

Parametrised N-channel merger that arbitrates several 32-bit source FIFOs (FE-I4 receivers, TLU controller, further data sources) onto the single read-side interface consumed by `out_fifo`. It replaces the hard-wired two-source TLU/FE access logic in the board top level. It adds round-robin or fixed-priority arbitration, configurable burst length per grant and per-channel enables. It sits between the per-channel FIFOs and `out_fifo` in the `BUS_CLK` domain.

## Interface
- `CHANNELS`, 2: number of source channels, 2..16.
- `DATA_WIDTH`, 32: word width.
- `MAX_BURST`, 1: maximum words read per grant before re-arbitration, 1..256.
- `FIXED_PRIORITY`, 0: 0 selects round-robin; 1 selects lowest index wins.

Ports (one clock; reset is synchronous and active-high):
- `BUS_CLK` in, 1: clock.
- `BUS_RST` in, 1: synchronous active-high reset.
- `CH_ENABLE` in, CHANNELS: per-channel arbitration enable.
- `CH_FIFO_EMPTY` in, CHANNELS: source empty flags.
- `CH_FIFO_DATA` in, CHANNELS*DATA_WIDTH: source head words, channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `CH_FIFO_READ` out, CHANNELS: read strobe to the source.
- `FIFO_READ` in, 1: read request from `out_fifo`.
- `FIFO_EMPTY` out, 1: merged empty flag.
- `FIFO_DATA` out, DATA_WIDTH: merged head word.
- `GRANT_VALID` out, 1: a channel currently holds the grant.
- `GRANT_ID` out, clog2(CHANNELS): index of the granted channel.

## Operation
- Request vector: `req[i] = CH_ENABLE[i] & ~CH_FIFO_EMPTY[i]`.
- States: IDLE (no grant) and GRANTED (grant register g, burst counter cnt).
- IDLE: if any req is set, the next edge grants the selected channel, sets cnt=0 and enters GRANTED.
- GRANTED, combinational pass-through:
  - `FIFO_EMPTY = CH_FIFO_EMPTY[g]`
  - `FIFO_DATA = CH_FIFO_DATA[g]`
  - `CH_FIFO_READ[g] = FIFO_READ & ~CH_FIFO_EMPTY[g]`
  - all other `CH_FIFO_READ` bits are 0.
- A forwarded read increments cnt. Width is clog2(MAX_BURST+1); cnt never wraps.
- Release conditions, evaluated at the edge:
  - (a) a forwarded read with cnt==MAX_BURST-1;
  - (b) `CH_FIFO_EMPTY[g]`=1 with no forwarded read;
  - (c) `CH_ENABLE[g]`=0. A read forwarded in that same cycle still completes.
- On release, if any req exists excluding g, the next channel is granted at that same edge with no idle cycle. Otherwise:
  - g is re-granted if still requesting and enabled, with cnt cleared;
  - else the block goes to IDLE.
- Round-robin: the search starts at g+1 modulo CHANNELS; in IDLE it starts after the last granted channel. Fixed priority: the lowest requesting index wins; the burst limit still forces re-arbitration.
- IDLE outputs: `FIFO_EMPTY`=1, `FIFO_DATA`=0, `CH_FIFO_READ`=0. `FIFO_READ` while `FIFO_EMPTY`=1 is never forwarded.

## Timing
- Reset values: GRANT_VALID=0, GRANT_ID=0, cnt=0, state=IDLE, `FIFO_EMPTY`=1, `FIFO_DATA`=0, `CH_FIFO_READ`=0. The round-robin pointer is set so channel 0 is searched first.
- Latency from a source going non-empty in IDLE to `FIFO_EMPTY`=0: 1 cycle.
- `FIFO_READ` to `CH_FIFO_READ`: 0 cycles, combinational. `out_fifo` timing is unchanged.
- Channel switch after a burst-ending read: the new channel's data is valid in the next cycle, so back-to-back reads across channels lose no cycle.
- Reset asserted mid-burst: the grant drops at that edge and no `CH_FIFO_READ` is asserted while `BUS_RST`=1.

## Structure
- Package `fifo_merge_pkg`:
  - state encoding (IDLE, GRANTED);
  - clog2 helper function;
  - default constants for CHANNELS, DATA_WIDTH and MAX_BURST.
- Sub-module `rr_priority_select`: combinational rotating-priority picker.
  - Inputs: req vector, start index, FIXED_PRIORITY.
  - Outputs: found flag, selected index.
- Top level `fifo_merge_arbiter` contains the state register, burst counter and output muxing.

## Test plan
- Reset, all sources empty: `FIFO_EMPTY`=1, GRANT_VALID=0; `FIFO_READ` pulses produce no `CH_FIFO_READ`.
- CHANNELS=2, MAX_BURST=1, both sources hold 3 words, continuous `FIFO_READ`: read order ch0,ch1,ch0,ch1,ch0,ch1, with no gap cycle between reads.
- CHANNELS=4, MAX_BURST=4, ch2 holds 10 words and ch1 holds 2 words, granted first: two reads from ch1 end by empty, then ch2 words are read in groups of 4, 4, 2. The 10 ch2 words arrive in order, each grant re-won by ch2 with cnt cleared.
- FIXED_PRIORITY=1, ch3 streaming and ch0 goes non-empty mid-burst with MAX_BURST=8: ch3 completes 8 reads, then ch0 is granted.
- `CH_ENABLE[g]` dropped in a cycle with `FIFO_READ`=1: that read is forwarded, and the next edge grants another channel or goes to IDLE.
- `BUS_RST` asserted during a grant with cnt=2: next cycle GRANT_VALID=0 and `FIFO_EMPTY`=1. After release, arbitration restarts at channel 0.
